// File: rtl/hero_pkg.sv
// Shared screen-state and keypad definitions for the hero game blocks.
// Used by the sequencer, the choose-hero logic and the display blocks.
package hero_pkg;

   localparam int unsigned KEY_W = 5;
   localparam int unsigned CNT_W = 32;

   typedef enum logic [2:0] {
      ST_OFF  = 3'd0,
      ST_WLCM = 3'd1,
      ST_CH   = 3'd2,
      ST_GAME = 3'd3,
      ST_WL   = 3'd4,
      ST_PA   = 3'd5
   } state_t;

   localparam logic [KEY_W-1:0] KEY_POWER   = 5'd15;
   localparam logic [KEY_W-1:0] KEY_CONFIRM = 5'd5;
   localparam logic [KEY_W-1:0] KEY_PAUSE   = 5'd10;

endpackage

// File: rtl/key_edge.sv
// Turns a held keypad press into one registered event carrying the key code.
// A press still held when reset is released produces no event until re-pressed.
module key_edge
   import hero_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             keypad_pressed,
   input  logic [KEY_W-1:0] key,
   output logic             evt,
   output logic [KEY_W-1:0] evt_key
);

   logic             r_armed;
   logic             r_prev;
   logic             r_evt;
   logic [KEY_W-1:0] r_key;
   logic             w_rise;

   // The first clock after reset only captures the key level, so a held key looks "already pressed".
   assign w_rise = r_armed & keypad_pressed & ~r_prev;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed <= 1'b0;
         r_prev  <= 1'b0;
         r_evt   <= 1'b0;
         r_key   <= '0;
      end else begin
         r_armed <= 1'b1;
         r_prev  <= keypad_pressed;
         r_evt   <= w_rise;
         if (w_rise) r_key <= key;
      end
   end

   assign evt     = r_evt;
   assign evt_key = r_key;

endmodule

// File: rtl/game_sequencer.sv
// Screen sequencer: power-up, welcome, hero choice, game, pause and win/lose
// screens, with life counting and a post-collision invulnerability window.
module game_sequencer
   import hero_pkg::*;
#(
   parameter int unsigned WLCM_CYCLES = 50_000_000,
   parameter int unsigned WL_CYCLES   = 100_000_000,
   parameter int unsigned INV_CYCLES  = 25_000_000,
   parameter int unsigned LIVES_INIT  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             keypad_pressed,
   input  logic [KEY_W-1:0] key,
   input  logic             collision,
   input  logic             goal,
   output logic [2:0]       presente,
   output logic [1:0]       lives,
   output logic             result,
   output logic             invuln,
   output logic             state_entry
);

   localparam logic [CNT_W-1:0] LP_WLCM_LAST = CNT_W'(WLCM_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_WL_LAST   = CNT_W'(WL_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_INV_LAST  = CNT_W'(INV_CYCLES - 1);

   state_t           r_state;
   logic             r_state_entry;
   logic [1:0]       r_lives;
   logic             r_result;
   logic             r_invuln;
   logic [CNT_W-1:0] r_dwell;
   logic [CNT_W-1:0] r_inv_cnt;

   logic             w_evt;
   logic [KEY_W-1:0] w_evt_key;
   logic             w_power, w_confirm, w_pause, w_hit;
   logic             w_change, w_start;
   state_t           w_next;

   key_edge u_key_edge (
      .clk           (clk),
      .rst_n         (rst_n),
      .keypad_pressed(keypad_pressed),
      .key           (key),
      .evt           (w_evt),
      .evt_key       (w_evt_key)
   );

   assign w_power   = w_evt && (w_evt_key == KEY_POWER);
   assign w_confirm = w_evt && (w_evt_key == KEY_CONFIRM);
   assign w_pause   = w_evt && (w_evt_key == KEY_PAUSE);
   assign w_hit     = collision && !r_invuln;

   // NOTE: w_next is defaulted before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_OFF:  if (w_power) w_next = ST_WLCM;
         ST_WLCM: if (w_power) w_next = ST_OFF;
                  else if (w_confirm || r_dwell == LP_WLCM_LAST) w_next = ST_CH;
         ST_CH:   if (w_power) w_next = ST_OFF;
                  else if (w_confirm) w_next = ST_GAME;
         ST_GAME: if (w_power) w_next = ST_OFF;
                  else if (w_hit) begin
                     if (r_lives <= 2'd1) w_next = ST_WL;
                  end
                  else if (goal) w_next = ST_WL;
                  else if (w_pause) w_next = ST_PA;
         ST_PA:   if (w_power) w_next = ST_OFF;
                  else if (w_pause) w_next = ST_GAME;
         ST_WL:   if (w_power) w_next = ST_OFF;
                  else if (w_confirm || r_dwell == LP_WL_LAST) w_next = ST_CH;
         default: w_next = ST_OFF;
      endcase
   end

   assign w_change = (w_next != r_state);
   assign w_start  = (r_state == ST_CH) && (w_next == ST_GAME);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_OFF;
         r_state_entry <= 1'b0;
         r_lives       <= 2'd0;
         r_result      <= 1'b0;
         r_invuln      <= 1'b0;
         r_dwell       <= '0;
         r_inv_cnt     <= '0;
      end else begin
         r_state       <= w_next;
         r_state_entry <= w_change;

         if (w_change)
            r_dwell <= '0;
         else if ((r_state == ST_WLCM || r_state == ST_WL) && r_dwell != '1)
            r_dwell <= r_dwell + 1'b1;

         if (w_start) begin
            r_lives   <= 2'(LIVES_INIT);
            r_invuln  <= 1'b0;
            r_inv_cnt <= '0;
            r_result  <= 1'b0;
         end else if (r_state == ST_GAME && w_next != ST_OFF) begin
            if (w_hit) begin
               // A fatal hit ends the game, so no invulnerability window is opened.
               r_lives   <= r_lives - 2'd1;
               r_invuln  <= (r_lives != 2'd1);
               r_inv_cnt <= '0;
               r_result  <= 1'b0;
            end else if (w_next == ST_WL) begin
               r_result <= 1'b1;
               r_invuln <= 1'b0;
            end else if (r_invuln) begin
               if (r_inv_cnt >= LP_INV_LAST) r_invuln <= 1'b0;
               else r_inv_cnt <= r_inv_cnt + 1'b1;
            end
         end else if (w_next == ST_OFF) begin
            r_invuln <= 1'b0;
         end
      end
   end

   assign presente    = r_state;
   assign lives       = r_lives;
   assign result      = r_result;
   assign invuln      = r_invuln;
   assign state_entry = r_state_entry;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with short dwell/invulnerability parameters.
module tb_game_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       keypad_pressed = 1'b0;
   logic [4:0] key = 5'd0;
   logic       collision = 1'b0;
   logic       goal = 1'b0;
   logic [2:0] presente;
   logic [1:0] lives;
   logic       result;
   logic       invuln;
   logic       state_entry;

   int n_pass   = 0;
   int n_checks = 0;
   int n_entry  = 0;

   localparam logic [4:0] K_POWER   = 5'd15;
   localparam logic [4:0] K_CONFIRM = 5'd5;
   localparam logic [4:0] K_PAUSE   = 5'd10;

   game_sequencer #(
      .WLCM_CYCLES(8),
      .WL_CYCLES  (6),
      .INV_CYCLES (4),
      .LIVES_INIT (3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .keypad_pressed(keypad_pressed),
      .key           (key),
      .collision     (collision),
      .goal          (goal),
      .presente      (presente),
      .lives         (lives),
      .result        (result),
      .invuln        (invuln),
      .state_entry   (state_entry)
   );

   always #5 clk = ~clk;

   // Entry pulses are sampled at the edge, so a pulse shows up in the count one edge later.
   always @(posedge clk) if (state_entry) n_entry++;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [4:0] k, input int hold);
      keypad_pressed = 1'b1;
      key            = k;
      tick(hold);
      keypad_pressed = 1'b0;
      key            = 5'd0;
   endtask

   task automatic test_reset();
      tick(2);
      n_checks++; if (presente !== 3'd0) $display("FAIL reset_presente: got %0d want 0", presente); else n_pass++;
      n_checks++; if (lives !== 2'd0) $display("FAIL reset_lives: got %0d want 0", lives); else n_pass++;
      n_checks++; if ({result, invuln, state_entry} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {result, invuln, state_entry}); else n_pass++;
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_welcome();
      int e0;
      e0 = n_entry;
      press(K_POWER, 1);
      tick(1);
      n_checks++; if (presente !== 3'd1) $display("FAIL power_on: got %0d want 1", presente); else n_pass++;
      n_checks++; if (state_entry !== 1'b1) $display("FAIL wlcm_entry_pulse: got %b want 1", state_entry); else n_pass++;
      tick(7);
      n_checks++; if (presente !== 3'd1) $display("FAIL wlcm_dwell_7: got %0d want 1", presente); else n_pass++;
      tick(1);
      n_checks++; if (presente !== 3'd2) $display("FAIL wlcm_dwell_8: got %0d want 2", presente); else n_pass++;
      tick(1);
      n_checks++; if (n_entry - e0 !== 2) $display("FAIL entry_count: got %0d want 2", n_entry - e0); else n_pass++;
      n_checks++; if (state_entry !== 1'b0) $display("FAIL entry_one_cycle: got %b want 0", state_entry); else n_pass++;
   endtask

   task automatic test_lives();
      press(K_CONFIRM, 1);
      tick(1);
      n_checks++; if (presente !== 3'd3) $display("FAIL start_game: got %0d want 3", presente); else n_pass++;
      n_checks++; if (lives !== 2'd3) $display("FAIL start_lives: got %0d want 3", lives); else n_pass++;
      collision = 1'b1; tick(1); collision = 1'b0;
      n_checks++; if ({lives, invuln} !== {2'd2, 1'b1}) $display("FAIL hit1: got lives=%0d inv=%b want 2/1", lives, invuln); else n_pass++;
      tick(2);
      collision = 1'b1; tick(1); collision = 1'b0;
      n_checks++; if ({lives, invuln} !== {2'd2, 1'b1}) $display("FAIL hit_in_window: got lives=%0d inv=%b want 2/1", lives, invuln); else n_pass++;
      tick(1);
      n_checks++; if (invuln !== 1'b0) $display("FAIL inv_window_end: got %b want 0", invuln); else n_pass++;
      collision = 1'b1; tick(1); collision = 1'b0;
      n_checks++; if ({lives, invuln} !== {2'd1, 1'b1}) $display("FAIL hit2: got lives=%0d inv=%b want 1/1", lives, invuln); else n_pass++;
      tick(4);
      n_checks++; if (invuln !== 1'b0) $display("FAIL inv_window_end2: got %b want 0", invuln); else n_pass++;
   endtask

   task automatic test_fatal();
      collision = 1'b1; goal = 1'b1; tick(1); collision = 1'b0; goal = 1'b0;
      n_checks++; if (presente !== 3'd4) $display("FAIL fatal_state: got %0d want 4", presente); else n_pass++;
      n_checks++; if ({result, lives} !== {1'b0, 2'd0}) $display("FAIL fatal_result: got res=%b lives=%0d want 0/0", result, lives); else n_pass++;
      tick(5);
      n_checks++; if (presente !== 3'd4) $display("FAIL wl_dwell_5: got %0d want 4", presente); else n_pass++;
      tick(1);
      n_checks++; if (presente !== 3'd2) $display("FAIL wl_dwell_6: got %0d want 2", presente); else n_pass++;
   endtask

   task automatic test_pause();
      press(K_CONFIRM, 1);
      tick(1);
      n_checks++; if ({presente, lives} !== {3'd3, 2'd3}) $display("FAIL restart: got st=%0d lives=%0d want 3/3", presente, lives); else n_pass++;
      collision = 1'b1; tick(1); collision = 1'b0;
      tick(1);
      keypad_pressed = 1'b1; key = K_PAUSE;
      tick(2);
      n_checks++; if (presente !== 3'd5) $display("FAIL pause_enter: got %0d want 5", presente); else n_pass++;
      collision = 1'b1; tick(1); collision = 1'b0;
      n_checks++; if ({presente, lives} !== {3'd5, 2'd2}) $display("FAIL pause_collision: got st=%0d lives=%0d want 5/2", presente, lives); else n_pass++;
      tick(17);
      keypad_pressed = 1'b0; key = 5'd0;
      tick(3);
      n_checks++; if ({presente, invuln} !== {3'd5, 1'b1}) $display("FAIL pause_hold: got st=%0d inv=%b want 5/1", presente, invuln); else n_pass++;
      press(K_PAUSE, 1);
      tick(1);
      n_checks++; if ({presente, invuln} !== {3'd3, 1'b1}) $display("FAIL pause_resume: got st=%0d inv=%b want 3/1", presente, invuln); else n_pass++;
      tick(1);
      n_checks++; if (invuln !== 1'b0) $display("FAIL inv_resumed_end: got %b want 0", invuln); else n_pass++;
   endtask

   task automatic test_reset_mid_game();
      rst_n = 1'b0;
      #1;
      n_checks++; if ({presente, lives} !== {3'd0, 2'd0}) $display("FAIL async_reset: got st=%0d lives=%0d want 0/0", presente, lives); else n_pass++;
      keypad_pressed = 1'b1; key = K_POWER;
      tick(2);
      rst_n = 1'b1;
      tick(5);
      n_checks++; if (presente !== 3'd0) $display("FAIL held_through_reset: got %0d want 0", presente); else n_pass++;
      keypad_pressed = 1'b0; key = 5'd0;
      tick(2);
      press(K_POWER, 1);
      tick(1);
      n_checks++; if (presente !== 3'd1) $display("FAIL repress_power: got %0d want 1", presente); else n_pass++;
   endtask

   task automatic test_power_off();
      press(K_POWER, 1);
      tick(1);
      n_checks++; if (presente !== 3'd0) $display("FAIL power_off: got %0d want 0", presente); else n_pass++;
      press(5'd7, 1);
      tick(2);
      n_checks++; if (presente !== 3'd0) $display("FAIL ignored_key: got %0d want 0", presente); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_welcome();
      test_lives();
      test_fatal();
      test_pause();
      test_reset_mid_game();
      test_power_off();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter WLCM_CYCLES, default 50_000_000, welcome-screen dwell in clk cycles.
REQ-002 SHALL have parameter WL_CYCLES, default 100_000_000, win/lose-screen dwell in clk cycles.
REQ-003 SHALL have parameter INV_CYCLES, default 25_000_000, post-collision invulnerability in clk cycles.
REQ-004 SHALL have parameter LIVES_INIT, default 3, lives loaded on game start (1..3).
REQ-005 SHALL have port clk, input, 1, sole clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port keypad_pressed, input, 1, level: a key is held.
REQ-008 SHALL have port key, input, 5, keypad code, valid while keypad_pressed.
REQ-009 SHALL have port collision, input, 1, one-cycle pulse from game logic: hero hit an obstacle.
REQ-010 SHALL have port goal, input, 1, one-cycle pulse from game logic: level completed.
REQ-011 SHALL have port presente, output, 3, current screen state.
REQ-012 SHALL have port lives, output, 2, remaining lives.
REQ-013 SHALL have port result, output, 1, 1 = win, 0 = lose; meaningful in WL.
REQ-014 SHALL have port invuln, output, 1, high while the invulnerability counter runs.
REQ-015 SHALL have port state_entry, output, 1, one-cycle pulse in the first cycle of every new state.

Function
REQ-016 States SHALL be OFF=0, WLCM=1, CH=2, GAME=3, WL=4, PA=5. Codes 6..7 SHALL go to OFF on the next clock.
REQ-017 A key event SHALL be the rising edge of keypad_pressed, registered one cycle. Exactly one event per press regardless of hold length. key SHALL be sampled at the edge.
REQ-018 Key codes: POWER=15, CONFIRM=5, PAUSE=10. All other codes SHALL be ignored.
REQ-019 OFF: POWER event -> WLCM.
REQ-020 WLCM: dwell counter reaches WLCM_CYCLES-1 -> CH. A CONFIRM event -> CH immediately.
REQ-021 CH: CONFIRM event -> GAME. On the same edge, lives <= LIVES_INIT, invuln cleared, result <= 0.
REQ-022 GAME: collision with invuln=0 -> lives decrements and INV_CYCLES counter starts. If lives was 1, go to WL with result=0 and lives=0.
REQ-023 GAME: collision with invuln=1 SHALL be ignored.
REQ-024 GAME: goal -> WL with result=1.
REQ-025 GAME: PAUSE event -> PA.
REQ-026 PA: PAUSE event -> GAME. While in PA the invuln counter SHALL freeze, and collision/goal SHALL be ignored.
REQ-027 WL: dwell counter reaches WL_CYCLES-1 -> CH. A CONFIRM event -> CH immediately.
REQ-028 POWER event in any state except OFF -> OFF.
REQ-029 Same-cycle priority SHALL be POWER > collision > goal > PAUSE/CONFIRM. Collision-to-zero-lives beats goal, so result=0.
REQ-030 The dwell counter SHALL clear on every state_entry and count only in WLCM and WL.
REQ-031 All outputs SHALL be registered. A transition SHALL be visible on presente one clock after the triggering event or edge.

Reset
REQ-032 On rst_n low, asynchronously: presente=OFF, lives=0, result=0, invuln=0, state_entry=0, counters=0, key edge register=0.
REQ-033 A press held across reset release SHALL not generate an event until released and pressed again. The edge register SHALL reset to 1 if keypad_pressed is high at the first clock.

Structure
REQ-034 State codes and key codes SHALL live in shared package hero_pkg, reused by choose-hero and display blocks.
REQ-035 Key rising-edge detection SHALL be sub-module key_edge (clk, rst_n, keypad_pressed, key -> evt, evt_key).
REQ-036 Counters SHALL be 32 bits, unsigned, with no wrap: each counter holds its terminal value until cleared.

Verification
REQ-037 Use WLCM_CYCLES=8, WL_CYCLES=6, INV_CYCLES=4, LIVES_INIT=3 in the bench.
REQ-038 Reset, then POWER press -> presente 0->1. With no key, presente=2 exactly 8 cycles after WLCM entry. state_entry pulses once per change.
REQ-039 CH, CONFIRM -> GAME, lives=3. Collision -> lives=2 and invuln high 4 cycles. Second collision inside the window -> lives stays 2. Collision after the window -> lives=1.
REQ-040 lives=1, collision and goal in the same cycle -> WL, result=0, lives=0. After 6 cycles -> CH.
REQ-041 GAME, PAUSE -> PA. Collision in PA -> ignored. PAUSE held 20 cycles -> a single event. PAUSE again -> GAME with the invuln count resumed.
REQ-042 rst_n asserted mid-GAME -> immediately OFF, lives=0. With the key held through release, no transition occurs until re-press.
